combfilter_n: RTL and testbench
===============================

# combfilter_n

Parametrised successor to the fixed 4-bit comb filter. It computes a feedforward or feedback comb response over a configurable delay depth, with a valid strobe and a runtime mode select. Unsigned samples go in and unsigned samples come out through a single registered output stage. It sits in the audio sample path, driven by one clock domain, and accepts at most one sample per cycle.

## Interface
- WIDTH, 4: sample width in bits, ≥ 2.
- DELAY, 8: comb delay D in accepted samples, ≥ 1.
- FB_SHIFT, 1: right-shift applied to the fed-back term, 0 ≤ FB_SHIFT < WIDTH.
- CLK_i  input  1  clock; all logic on rising edge.
- RST_i  input  1  synchronous, active-high reset.
- valid_i  input  1  data_in holds a new sample this cycle.
- data_in  input  WIDTH  unsigned input sample x[n].
- mode_i  input  2  00 FF-add, 01 FF-sub, 10 FB-add, 11 pass-through.
- data_out  output  WIDTH  unsigned output sample y[n], registered.
- valid_o  output  1  data_out updated this cycle; one-cycle pulse per accepted sample.
- primed_o  output  1  delay line holds DELAY samples, so the delayed term is live.

## Operation
- A sample is accepted on a rising edge with valid_i=1 and RST_i=0. Only accepted samples advance the delay line, the pointer and the fill count.
- The delayed term d is defined as follows:
  - d = 0 while fill < DELAY.
  - Otherwise, d is the delay-line word written DELAY accepted samples earlier.
- Output per mode:
  - FF-add: y = x + d, where the line stores x.
  - FF-sub: y = x − d, where the line stores x.
  - FB-add: y = x + (d >> FB_SHIFT), where the line stores y after limiting.
  - Pass-through: y = x, the line stores x, and d is ignored.
- Arithmetic is computed at WIDTH+1 bits, then limited to WIDTH bits per the Configuration section.
- The write pointer wraps from DELAY−1 to 0.
- The fill counter saturates at DELAY.
- primed_o = (fill == DELAY), registered.
- Mode change: if an accepted sample carries a mode_i different from the mode of the previous accepted sample:
  - Fill is cleared before that sample is processed, so d = 0 for it.
  - After the sample, fill = 1 and primed_o = 0.
  - The pointer is not reset.
- Reset sets data_out=0, valid_o=0, primed_o=0, pointer=0, fill=0, and the stored mode to 00. Delay-line contents are not cleared; the fill count masks them.
- RST_i together with valid_i: reset wins and the sample is discarded.
- Reset asserted mid-stream: all state returns to reset values on that edge.

## Timing
- Latency is one cycle: a sample accepted at edge k gives data_out and valid_o=1 after edge k, held until edge k+1.
- valid_o is low in every cycle after an edge where no sample was accepted. data_out holds its last value while valid_o is low.
- Full throughput: valid_i may be high every cycle, with no backpressure.
- primed_o rises after the edge that accepts the DELAY-th sample. The (DELAY+1)-th sample is the first to use a non-zero d.
- FB-add feedback is the limited y, written on the same edge it is registered.

## Configuration
- COMBFILTER_SAT_EN defined: results saturate.
  - A sum above 2^WIDTH−1 gives 2^WIDTH−1.
  - A difference below 0 gives 0.
- COMBFILTER_SAT_EN undefined: results wrap modulo 2^WIDTH, keeping the low WIDTH bits.

## Structure
- Package combfilter_pkg holds:
  - Mode encodings MODE_FF_ADD=2'b00, MODE_FF_SUB=2'b01, MODE_FB_ADD=2'b10, MODE_PASS=2'b11.
  - The mode typedef.
- Sub-module comb_delay_line, a DELAY×WIDTH circular buffer, owns:
  - Write/read pointer, with read-before-write on the same address.
  - Fill counter and primed flag.
  - A clear_fill input.
- The top level owns mode tracking, arithmetic and limiting, and the output registers.

## Test plan
All scenarios use WIDTH=4, DELAY=8, FB_SHIFT=1.
- Reset: RST_i high for 2 cycles with valid_i=1 and data_in=7 → data_out=0, valid_o=0, primed_o=0 throughout; no sample accepted.
- FF-add impulse: x=5 followed by zeros, valid_i every cycle → outputs 5, then 0 ×7, then 5, then 0; primed_o rises after the 8th sample.
- FF-sub step: constant 3 → 3 for samples 1–8, then 0 from sample 9 onward.
- Limiting:
  - FF-add with constant 12 → samples 9+ give 15 with SAT_EN, 8 without.
  - FF-sub with 9 ×8 then 1 → sample 9 gives 0 with SAT_EN, 8 without.
- FB-add impulse: x=8 followed by zeros → 8 at samples 1, 9, 17 and 25 becomes 8, 4, 2, 1, then 0 from sample 33.
- Gaps and mode switch: valid_i toggled with 0–3 idle cycles between samples → identical sample sequence to the gapless run, valid_o pulses once per sample. Switching FF-add to FF-sub at sample 12 → that sample gives d=0, primed_o drops, and d is live again from sample 20.

Source files
------------

// File: rtl/combfilter_pkg.sv
// -----------------------------------------------------------------------------
// combfilter_pkg
//
// Shared definitions for the combfilter_n comb filter and its delay line.
//
// Contents:
//   mode_t          runtime mode select carried on mode_i
//     MODE_FF_ADD   2'b00  y = x + d,             line stores x
//     MODE_FF_SUB   2'b01  y = x - d,             line stores x
//     MODE_FB_ADD   2'b10  y = x + (d >> shift),  line stores limited y
//     MODE_PASS     2'b11  y = x,                 line stores x
//   ptr_width()     pointer width for a circular buffer of a given depth,
//                   never less than one bit so a depth of 1 still elaborates
// -----------------------------------------------------------------------------
package combfilter_pkg;

    typedef enum logic [1:0] {
        MODE_FF_ADD = 2'b00,
        MODE_FF_SUB = 2'b01,
        MODE_FB_ADD = 2'b10,
        MODE_PASS   = 2'b11
    } mode_t;

    // Width of an index that addresses 0 .. depth-1.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage : combfilter_pkg

// File: rtl/combfilter_n_if.sv
// -----------------------------------------------------------------------------
// combfilter_n_if
//
// Sample-path bundle between a sample source and combfilter_n.
//
// Handshake: a sample is transferred on every rising clock edge where
// valid_i is high (and the filter is not in reset). There is no ready/
// backpressure; the filter accepts one sample per cycle unconditionally.
// valid_o is a one-cycle pulse marking the cycle data_out carries the
// result for the sample accepted on the preceding edge.
//
// Signals:
//   valid_i   source -> filter   data_in/mode_i hold a new sample
//   data_in   source -> filter   unsigned sample x[n], WIDTH bits
//   mode_i    source -> filter   mode for this sample (combfilter_pkg::mode_t)
//   data_out  filter -> source   unsigned result y[n], registered
//   valid_o   filter -> source   data_out updated this cycle
//   primed_o  filter -> source   delay line full, delayed term is live
//
// Modports:
//   master  the sample source (drives valid_i/data_in/mode_i)
//   slave   the filter
// -----------------------------------------------------------------------------
interface combfilter_n_if #(
    parameter int WIDTH = 4
);

    logic                  valid_i;
    logic [WIDTH-1:0]      data_in;
    combfilter_pkg::mode_t mode_i;
    logic [WIDTH-1:0]      data_out;
    logic                  valid_o;
    logic                  primed_o;

    modport master (
        output valid_i,
        output data_in,
        output mode_i,
        input  data_out,
        input  valid_o,
        input  primed_o
    );

    modport slave (
        input  valid_i,
        input  data_in,
        input  mode_i,
        output data_out,
        output valid_o,
        output primed_o
    );

endinterface : combfilter_n_if

// File: rtl/comb_delay_line.sv
// -----------------------------------------------------------------------------
// comb_delay_line
//
// DELAY x WIDTH circular buffer holding the comb filter history, together
// with the fill count that says how much of that history is valid.
//
// The read port is combinational on the current write pointer. Because the
// buffer is exactly DELAY deep, the word at the write pointer is the one
// written DELAY accepted samples ago; it is read before being overwritten
// on the same edge.
//
// The buffer contents are never reset. The fill count masks stale words,
// and primed only rises once DELAY fresh words have been written.
//
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-high reset (pointer, fill, primed)
//   wr_en       an accepted sample: write wr_data, advance pointer and fill
//   wr_data     word to store at the write pointer
//   clear_fill  with wr_en: restart the fill count before this write, so the
//               fill count afterwards is 1 (pointer keeps advancing)
//   rd_data     word written DELAY accepted samples ago (valid when primed)
//   primed      registered, fill count == DELAY
//   fill_dbg    current fill count, for observation only
// -----------------------------------------------------------------------------
module comb_delay_line
    import combfilter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DELAY = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         clear_fill,
    output logic [WIDTH-1:0]             rd_data,
    output logic                         primed,
    output logic [$clog2(DELAY+1)-1:0]   fill_dbg
);

    localparam int PTR_W  = ptr_width(DELAY);
    localparam int FILL_W = $clog2(DELAY + 1);

    localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(DELAY - 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DELAY);

    logic [WIDTH-1:0]  mem [DELAY];
    logic [PTR_W-1:0]  ptr;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fill_base;
    logic [FILL_W-1:0] fill_next;

    assign rd_data  = mem[ptr];
    assign fill_dbg = fill;

    // Fill count after this edge: restart from zero on a mode change, then
    // count the sample being written, saturating at DELAY.
    always_comb begin
        fill_base = clear_fill ? '0 : fill;
        fill_next = fill;
        if (wr_en) begin
            fill_next = (fill_base == FILL_MAX) ? FILL_MAX
                                                : fill_base + FILL_W'(1);
        end
    end

    // Storage has no reset; stale words are hidden by the fill count.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr    <= '0;
            fill   <= '0;
            primed <= 1'b0;
        end else begin
            if (wr_en) begin
                ptr <= (ptr == PTR_LAST) ? '0 : ptr + PTR_W'(1);
            end
            fill   <= fill_next;
            primed <= (fill_next == FILL_MAX);
        end
    end

endmodule : comb_delay_line

// File: rtl/combfilter_n.sv
// -----------------------------------------------------------------------------
// combfilter_n
//
// Parametrised comb filter on an unsigned sample stream. Each accepted
// sample x produces one registered result y one cycle later:
//   FF-add : y = x + d              (history stores x)
//   FF-sub : y = x - d              (history stores x)
//   FB-add : y = x + (d >> FB_SHIFT) (history stores the limited y)
//   pass   : y = x                  (history stores x)
// where d is the history word from DELAY accepted samples earlier, or 0
// while the history is not yet full.
//
// Arithmetic is done at WIDTH+1 bits. Build option:
//   COMBFILTER_SAT_EN defined   : sums clamp to 2^WIDTH-1, differences to 0
//   COMBFILTER_SAT_EN undefined : results wrap modulo 2^WIDTH
//
// A sample whose mode differs from the previous accepted sample restarts
// the history fill, so that sample and the following DELAY-1 samples see
// d = 0. The write pointer is not disturbed.
//
// Parameters:
//   WIDTH     sample width (>= 2)
//   DELAY     comb delay in accepted samples (>= 1)
//   FB_SHIFT  right shift on the fed-back term (0 .. WIDTH-1)
//
// Ports:
//   CLK_i     clock, rising edge
//   RST_i     synchronous active-high reset; wins over valid_i
//   bus       combfilter_n_if slave: valid_i, data_in, mode_i in;
//             data_out, valid_o, primed_o out
//   mode_dbg  stored mode of the last accepted sample, for observation
// -----------------------------------------------------------------------------
module combfilter_n
    import combfilter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int DELAY    = 8,
    parameter int FB_SHIFT = 1
) (
    input  logic              CLK_i,
    input  logic              RST_i,
    combfilter_n_if.slave     bus,
    output mode_t             mode_dbg
);

    // -------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // -------------------------------------------------------------------
    if (WIDTH < 2) begin : g_bad_width
        $error("combfilter_n: WIDTH must be >= 2");
    end
    if (DELAY < 1) begin : g_bad_delay
        $error("combfilter_n: DELAY must be >= 1");
    end
    if (FB_SHIFT < 0 || FB_SHIFT >= WIDTH) begin : g_bad_shift
        $error("combfilter_n: FB_SHIFT must be in 0 .. WIDTH-1");
    end

    // -------------------------------------------------------------------
    // Declarations
    // -------------------------------------------------------------------
    logic                        accept;
    logic                        mode_change;
    mode_t                       mode_q;
    logic [WIDTH-1:0]            line_rd;
    logic                        line_primed;
    logic [$clog2(DELAY+1)-1:0]  line_fill;
    logic [WIDTH-1:0]            d_term;
    logic [WIDTH-1:0]            d_fb;
    logic [WIDTH:0]              x_ext;
    logic [WIDTH:0]              sum_ff;
    logic [WIDTH:0]              diff_ff;
    logic [WIDTH:0]              sum_fb;
    logic [WIDTH-1:0]            y_next;
    logic [WIDTH-1:0]            line_wr;
    logic [WIDTH-1:0]            data_q;
    logic                        valid_q;

    // -------------------------------------------------------------------
    // Limiting helpers
    // -------------------------------------------------------------------
    // Addition carry lands in bit WIDTH; subtraction borrow also sets bit
    // WIDTH because both operands are zero-extended.
    function automatic logic [WIDTH-1:0] limit_add(input logic [WIDTH:0] s);
`ifdef COMBFILTER_SAT_EN
        return s[WIDTH] ? {WIDTH{1'b1}} : s[WIDTH-1:0];
`else
        return s[WIDTH-1:0];
`endif
    endfunction

    function automatic logic [WIDTH-1:0] limit_sub(input logic [WIDTH:0] s);
`ifdef COMBFILTER_SAT_EN
        return s[WIDTH] ? {WIDTH{1'b0}} : s[WIDTH-1:0];
`else
        return s[WIDTH-1:0];
`endif
    endfunction

    // -------------------------------------------------------------------
    // Acceptance and mode tracking
    // -------------------------------------------------------------------
    assign accept      = bus.valid_i && !RST_i;
    assign mode_change = (bus.mode_i != mode_q);
    assign mode_dbg    = mode_q;

    // -------------------------------------------------------------------
    // History
    // -------------------------------------------------------------------
    comb_delay_line #(
        .WIDTH (WIDTH),
        .DELAY (DELAY)
    ) u_line (
        .clk        (CLK_i),
        .rst        (RST_i),
        .wr_en      (accept),
        .wr_data    (line_wr),
        .clear_fill (mode_change),
        .rd_data    (line_rd),
        .primed     (line_primed),
        .fill_dbg   (line_fill)
    );

    // The delayed term is live only with a full history; a mode change
    // clears the fill before this sample, so it must see d = 0 as well.
    assign d_term = (line_primed && !mode_change) ? line_rd : '0;
    assign d_fb   = d_term >> FB_SHIFT;

    // -------------------------------------------------------------------
    // Arithmetic
    // -------------------------------------------------------------------
    assign x_ext   = {1'b0, bus.data_in};
    assign sum_ff  = x_ext + {1'b0, d_term};
    assign diff_ff = x_ext - {1'b0, d_term};
    assign sum_fb  = x_ext + {1'b0, d_fb};

    always_comb begin
        y_next  = bus.data_in;
        line_wr = bus.data_in;
        case (bus.mode_i)
            MODE_FF_ADD: y_next = limit_add(sum_ff);
            MODE_FF_SUB: y_next = limit_sub(diff_ff);
            MODE_FB_ADD: begin
                y_next  = limit_add(sum_fb);
                // Feedback path stores the limited result, not the input.
                line_wr = limit_add(sum_fb);
            end
            MODE_PASS:   y_next = bus.data_in;
            default:     y_next = bus.data_in;
        endcase
    end

    // -------------------------------------------------------------------
    // Output stage and stored mode
    // -------------------------------------------------------------------
    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            mode_q  <= MODE_FF_ADD;
        end else if (bus.valid_i) begin
            data_q  <= y_next;
            valid_q <= 1'b1;
            mode_q  <= bus.mode_i;
        end else begin
            valid_q <= 1'b0;
        end
    end

    assign bus.data_out = data_q;
    assign bus.valid_o  = valid_q;
    assign bus.primed_o = line_primed;

    // The fill count is exported for observation; nothing here consumes it.
    logic unused_ok;
    assign unused_ok = ^line_fill;

endmodule : combfilter_n

// File: tb/tb_combfilter_n.sv
module tb_combfilter_n;
  import combfilter_pkg::*;

  localparam int WIDTH    = 4;
  localparam int DELAY    = 8;
  localparam int FB_SHIFT = 1;
  localparam int MAXV     = (1 << WIDTH) - 1;

  // ---------------- clock / reset ----------------
  logic  clk = 1'b0;
  logic  rst;
  mode_t mode_dbg;

  combfilter_n_if #(.WIDTH(WIDTH)) bus ();

  combfilter_n #(
    .WIDTH    (WIDTH),
    .DELAY    (DELAY),
    .FB_SHIFT (FB_SHIFT)
  ) dut (
    .CLK_i    (clk),
    .RST_i    (rst),
    .bus      (bus),
    .mode_dbg (mode_dbg)
  );

  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;

  logic [WIDTH:0] exp_q[$];   // {primed, data}
  int             obs_q[$];   // observed data_out values, for directed checks

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // History of stored words indexed by absolute accepted-sample number;
  // seg_start is the sample number at which the current history run began
  // (reset or mode change).
  int    hist[$];
  int    n_acc     = 0;
  int    seg_start = 0;
  mode_t prev_mode = MODE_FF_ADD;

  function automatic int lim(input int v);
`ifdef COMBFILTER_SAT_EN
    if (v > MAXV) return MAXV;
    if (v < 0) return 0;
    return v;
`else
    return v & MAXV;
`endif
  endfunction

  function automatic void model_step(input int x, input mode_t m,
                                     output int y, output int primed);
    int d;
    if (m != prev_mode) seg_start = n_acc;
    prev_mode = m;
    d = (n_acc - seg_start >= DELAY) ? hist[n_acc - DELAY] : 0;
    case (m)
      MODE_FF_ADD: y = lim(x + d);
      MODE_FF_SUB: y = lim(x - d);
      MODE_FB_ADD: y = lim(x + (d >> FB_SHIFT));
      default:     y = x;
    endcase
    hist.push_back((m == MODE_FB_ADD) ? y : x);
    n_acc++;
    primed = (n_acc - seg_start >= DELAY) ? 1 : 0;
  endfunction

  function automatic void model_reset();
    seg_start = n_acc;
    prev_mode = MODE_FF_ADD;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  logic [WIDTH:0] mon_e;
  always @(negedge clk) begin
    if (bus.valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid_o", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("data_out", int'(bus.data_out), int'(mon_e[WIDTH-1:0]));
        check("primed_o", int'(bus.primed_o), int'(mon_e[WIDTH]));
        obs_q.push_back(int'(bus.data_out));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input int x, input mode_t m, input int gap);
    int y, pr;
    @(negedge clk);
    bus.valid_i = 1'b1;
    bus.data_in = WIDTH'(x);
    bus.mode_i  = m;
    model_step(x, m, y, pr);
    exp_q.push_back({pr[0], WIDTH'(y)});
    repeat (gap) begin
      @(negedge clk);
      bus.valid_i = 1'b0;
      bus.data_in = WIDTH'($urandom_range(0, MAXV));
    end
  endtask

  task automatic drain();
    int budget;
    @(negedge clk);
    bus.valid_i = 1'b0;
    budget = 0;
    while (exp_q.size() != 0 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (exp_q.size() != 0) begin
      check("drain_outstanding", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  // Reset with a sample presented: it must be discarded.
  task automatic do_reset();
    @(negedge clk);
    rst         = 1'b1;
    bus.valid_i = 1'b1;
    bus.data_in = WIDTH'(7);
    bus.mode_i  = MODE_FB_ADD;
    repeat (2) begin
      @(negedge clk);
      check("reset_data_out", int'(bus.data_out), 0);
      check("reset_valid_o",  int'(bus.valid_o),  0);
      check("reset_primed_o", int'(bus.primed_o), 0);
    end
    rst         = 1'b0;
    bus.valid_i = 1'b0;
    model_reset();
    obs_q.delete();
  endtask

  task automatic impulse_ff_add(input int max_gap);
    int want[10];
    want = '{5, 0, 0, 0, 0, 0, 0, 0, 5, 0};
    do_reset();
    send(5, MODE_FF_ADD, $urandom_range(0, max_gap));
    for (int i = 0; i < 9; i++) send(0, MODE_FF_ADD, $urandom_range(0, max_gap));
    drain();
    check("impulse_count", obs_q.size(), 10);
    for (int i = 0; i < 10 && i < obs_q.size(); i++)
      check($sformatf("impulse_y%0d", i + 1), obs_q[i], want[i]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int xs[$];
    int x;
    mode_t m;

    rst         = 1'b1;
    bus.valid_i = 1'b1;
    bus.data_in = WIDTH'(7);
    bus.mode_i  = MODE_FF_ADD;

    // FF-add impulse, gapless then with random idle cycles
    impulse_ff_add(0);
    impulse_ff_add(3);

    // FF-sub step
    do_reset();
    for (int i = 0; i < 10; i++) send(3, MODE_FF_SUB, 0);
    drain();
    check("step_y8",  obs_q[7], 3);
    check("step_y9",  obs_q[8], 0);
    check("step_y10", obs_q[9], 0);

    // Limiting: add
    do_reset();
    for (int i = 0; i < 10; i++) send(12, MODE_FF_ADD, 0);
    drain();
`ifdef COMBFILTER_SAT_EN
    check("lim_add_y9", obs_q[8], 15);
`else
    check("lim_add_y9", obs_q[8], 8);
`endif

    // Limiting: subtract
    do_reset();
    for (int i = 0; i < 8; i++) send(9, MODE_FF_SUB, 0);
    send(1, MODE_FF_SUB, 0);
    drain();
`ifdef COMBFILTER_SAT_EN
    check("lim_sub_y9", obs_q[8], 0);
`else
    check("lim_sub_y9", obs_q[8], 8);
`endif

    // FB-add impulse decays by FB_SHIFT each pass
    do_reset();
    send(8, MODE_FB_ADD, 0);
    for (int i = 0; i < 35; i++) send(0, MODE_FB_ADD, 0);
    drain();
    check("fb_y1",  obs_q[0],  8);
    check("fb_y9",  obs_q[8],  4);
    check("fb_y17", obs_q[16], 2);
    check("fb_y25", obs_q[24], 1);
    check("fb_y33", obs_q[32], 0);

    // Mode switch FF-add -> FF-sub at sample 12, with gaps
    do_reset();
    xs.delete();
    for (int i = 0; i < 25; i++) begin
      x = $urandom_range(0, MAXV);
      xs.push_back(x);
      send(x, (i < 11) ? MODE_FF_ADD : MODE_FF_SUB, $urandom_range(0, 3));
    end
    drain();
    check("switch_y12_d0", obs_q[11], xs[11]);

    // Randomised mixed-mode stream with occasional mode changes and gaps
    do_reset();
    m = MODE_FF_ADD;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) m = mode_t'($urandom_range(0, 3));
      if (i == 200) begin
        drain();
        do_reset();
      end
      send($urandom_range(0, MAXV), m, $urandom_range(0, 3));
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_combfilter_n
